imm_extend_pipe: RTL
====================

// Module: imm_extend_pipe
// PURPOSE
//  Parametrised, pipelined immediate-extension unit for the MIPS datapath.
//  Widens an IN_W-bit instruction immediate to OUT_W bits in one of four modes
//  (sign, zero, LUI-upper, branch-offset), behind a valid/ready handshake.
//  A 2-entry skid buffer gives full throughput under back-pressure.
//  Sits between the decode stage and the ALU/branch-target operand muxes.
// PARAMETERS
//  IN_W   16  immediate input width; legal range IN_W >= 2.
//  OUT_W  32  extended output width; legal range OUT_W >= IN_W+2.
// PORTS
//  i_clk         in   1      clock; all state changes on the rising edge.
//  i_rst_n       in   1      synchronous reset, active low.
//  i_flush       in   1      synchronous flush; empties the pipe.
//  i_valid       in   1      upstream data valid.
//  o_ready       out  1      unit can accept data this cycle.
//  i_mode        in   2      00 sign, 01 zero, 10 upper, 11 branch.
//  i_imm         in   IN_W   raw immediate.
//  o_valid       out  1      o_data holds a valid result.
//  i_ready       in   1      downstream accepts o_data this cycle.
//  o_data        out  OUT_W  extended immediate.
// BEHAVIOUR
//  - Reset: on a rising edge with i_rst_n=0:
//      - state=EMPTY, o_valid=0, o_data=0, skid register=0, o_ready=1.
//      - i_valid and i_flush are ignored in that cycle.
//      - Reset mid-transfer discards all held data; no partial result remains.
//  - Handshake:
//      - in_fire = i_valid & o_ready; out_fire = o_valid & i_ready.
//      - i_mode and i_imm are sampled only on in_fire.
//      - o_data/o_valid are stable while o_valid=1 and i_ready=0.
//  - Extension is computed on the input side and registered:
//      - 00 sign:   {{(OUT_W-IN_W){imm[IN_W-1]}}, imm}
//      - 01 zero:   {{(OUT_W-IN_W){1'b0}}, imm}
//      - 10 upper:  imm placed in the high bits: {imm, {(OUT_W-IN_W){1'b0}}}
//        when OUT_W >= 2*IN_W; otherwise (imm << (OUT_W-IN_W)) truncated to OUT_W.
//      - 11 branch: sign-extend, then << 2; the 2 MSBs shifted out are dropped.
//  - Latency: 1 cycle from in_fire to o_valid when the unit is EMPTY.
//  - State machine (o_valid = state!=EMPTY; o_ready = state!=FULL, registered):
//      - EMPTY:
//          - in_fire -> ONE (result -> output reg).
//      - ONE:
//          - in_fire & !out_fire -> FULL (result -> skid reg).
//          - !in_fire & out_fire -> EMPTY.
//          - in_fire & out_fire -> ONE (result -> output reg).
//      - FULL:
//          - out_fire -> ONE (skid -> output reg). No input is accepted in FULL.
//  - Order: results leave in strict acceptance order; none dropped or duplicated.
//  - Flush:
//      - i_flush=1 (with i_rst_n=1) -> EMPTY, o_valid=0, o_ready=1 next cycle.
//      - Flush has priority over a simultaneous in_fire or out_fire.
//      - A beat that fires in the flush cycle is discarded; o_data holds its old value.
//  - Throughput: one result per cycle while i_ready=1.
// TESTING
//  1. Reset: hold i_rst_n=0 for 2 clocks with i_valid=1
//     -> o_valid=0, o_data=0, o_ready=1 after release.
//  2. Modes, IN_W=16/OUT_W=32, i_ready=1:
//     - 00/0x8000 -> 0xFFFF8000
//     - 01/0x8000 -> 0x00008000
//     - 10/0x1234 -> 0x12340000
//     - 11/0xFFFF -> 0xFFFFFFFC
//     - each appears 1 cycle after in_fire.
//  3. Back-pressure: i_ready=0, offer 0x0001,0x0002,0x0003 in mode 01
//     -> o_ready drops after 2 accepts.
//     Raise i_ready -> out 0x1,0x2, then 0x3 is accepted and output.
//  4. Streaming: 16 back-to-back beats with i_ready=1
//     -> o_valid continuous, 16 outputs in order, o_ready never drops.
//  5. Flush in FULL plus simultaneous in_fire attempt
//     -> next cycle o_valid=0, o_ready=1; no stale data later emitted.
//  6. Param sweep IN_W=8/OUT_W=16:
//     - 00/0x80 -> 0xFF80
//     - 10/0x12 -> 0x1200
//     - 11/0x7F -> 0x01FC

Source files
------------

// File: rtl/imm_extend_pipe.sv
// Immediate extension unit: sign/zero/upper/branch widening of a decode
// immediate, registered behind a valid/ready handshake with a 2-entry skid.
module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [1:0]       i_mode,
  input  logic [IN_W-1:0]  i_imm,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [OUT_W-1:0] o_data
);

  localparam int PAD = OUT_W - IN_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             valid_q, valid_d;
  logic             ready_q, ready_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic [OUT_W-1:0] skid_q, skid_d;

  logic             in_fire;
  logic             out_fire;
  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] ext;

  assign in_fire  = i_valid & ready_q;
  assign out_fire = valid_q & i_ready;

  // Upper mode: shifting the zero-extended value by PAD both places imm
  // at the top and truncates it when OUT_W < 2*IN_W.
  always_comb begin
    sext = {{PAD{i_imm[IN_W-1]}}, i_imm};
    zext = {{PAD{1'b0}}, i_imm};
    ext  = sext;
    unique case (i_mode)
      2'b00: ext = sext;
      2'b01: ext = zext;
      2'b10: ext = zext << PAD;
      2'b11: ext = sext << 2;
      default: ext = sext;
    endcase
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    skid_d  = skid_q;
    if (i_flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = ONE;
            data_d  = ext;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            data_d = ext;
          end else if (in_fire) begin
            state_d = FULL;
            skid_d  = ext;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d = ONE;
            data_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    valid_d = (state_d != EMPTY);
    ready_d = (state_d != FULL);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      data_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      data_q  <= data_d;
      skid_q  <= skid_d;
    end
  end

  assign o_valid = valid_q;
  assign o_ready = ready_q;
  assign o_data  = data_q;

endmodule
